// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory-access stage: bus layouts,
// access size codes, FSM states and the store lane-alignment helper.
package mem_pkg;

  localparam int EXE_MEM_W = 160;
  localparam int MEM_WB_W  = 157;

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Bit offsets inside the 5-bit mem_ctrl field {load, store, size[1:0], sign}
  localparam int CTRL_LOAD  = 4;
  localparam int CTRL_STORE = 3;
  localparam int CTRL_SIZE  = 1;
  localparam int CTRL_SIGN  = 0;

  typedef struct packed {
    logic [4:0]  memCtrl;
    logic [31:0] storeData;
    logic [31:0] exeResult;
    logic [31:0] loResult;
    logic        hiWrite, loWrite, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0rAddr;
    logic        syscall, eret, brk, fetchError, instReserved, overflow, delaySlot, wen;
    logic [4:0]  wdest;
    logic [31:0] pc;
  } exe_mem_t;

  typedef struct packed {
    logic        wen;
    logic [4:0]  wdest;
    logic [31:0] memResult;
    logic [31:0] loResult;
    logic        hiWrite, loWrite, mfhi, mflo, mtc0, mfc0;
    logic [7:0]  cp0rAddr;
    logic        syscall, eret, brk, fetchError, instReserved, raddrError, waddrError, overflow;
    logic [31:0] dmAddr;
    logic        delaySlot;
    logic [31:0] pc;
  } mem_wb_t;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } store_t;

  // Sub-word stores replicate the datum across the word so the strobes pick the lane
  function automatic store_t storeAlign(input logic [1:0] size, input logic [1:0] addr,
                                        input logic [31:0] sd);
    store_t s;
    case (size)
      SIZE_BYTE: begin
        s.wstrb = 4'b0001 << addr;
        s.wdata = {4{sd[7:0]}};
      end
      SIZE_HALF: begin
        s.wstrb = addr[1] ? 4'b1100 : 4'b0011;
        s.wdata = {2{sd[15:0]}};
      end
      default: begin
        s.wstrb = 4'b1111;
        s.wdata = sd;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_if.sv
// Data-memory req/ack port: the stage drives the request side (master),
// the memory answers with read data and a one-cycle ack (slave).
interface mem_if;
  logic        dm_req;
  logic        dm_wr;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (output dm_req, dm_wr, dm_addr, dm_wstrb, dm_wdata,
                  input  dm_rdata, dm_ack);
  modport slave  (input  dm_req, dm_wr, dm_addr, dm_wstrb, dm_wdata,
                  output dm_rdata, dm_ack);
endinterface

// File: rtl/mem_load_align.sv
// Load data extraction: selects the addressed byte/half of a read word and
// sign- or zero-extends it; word loads pass through.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  output logic [31:0] data_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    byteSel = rdata_i[{addr_i, 3'b000} +: 8];
    halfSel = rdata_i[{addr_i[1], 4'b0000} +: 16];
    case (size_i)
      SIZE_BYTE: data_o = {{24{sign_i & byteSel[7]}}, byteSel};
      SIZE_HALF: data_o = {{16{sign_i & halfSel[15]}}, halfSel};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem.sv
// MIPS MEM stage: issues at most one data-memory access per instruction over
// req/ack, aligns stores, extracts loads and builds the MEM->WB bus.
module mem
  import mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 MEM_valid,
  input  logic [EXE_MEM_W-1:0] EXE_MEM_bus_r,
  input  logic                 WB_allow_in,
  input  logic                 cancel,
  output logic                 MEM_over,
  output logic [MEM_WB_W-1:0]  MEM_WB_bus,
  output logic [4:0]           MEM_wdest,
  output logic [31:0]          MEM_pc,
  mem_if.master                dm
);

  exe_mem_t    ex;
  mem_wb_t     wb;
  store_t      stAlign;
  state_e      stateQ, stateD;
  logic        isLoad, isStore, signExt, misalign, priorExc, access;
  logic [1:0]  sizeCode, addrLo;
  logic        dmWrQ, dmWrD;
  logic [31:0] dmAddrQ, dmAddrD, dmWdataQ, dmWdataD, rdataQ, rdataD;
  logic [3:0]  dmWstrbQ, dmWstrbD;
  logic [31:0] loadData;
  logic        dmReq, memOver, useCapture;

  assign ex       = exe_mem_t'(EXE_MEM_bus_r);
  assign isLoad   = ex.memCtrl[CTRL_LOAD];
  assign isStore  = ex.memCtrl[CTRL_STORE];
  assign sizeCode = ex.memCtrl[CTRL_SIZE +: 2];
  assign signExt  = ex.memCtrl[CTRL_SIGN];
  assign addrLo   = ex.exeResult[1:0];

  assign misalign = ((sizeCode == SIZE_WORD) && (addrLo != 2'b00)) ||
                    ((sizeCode == SIZE_HALF) && addrLo[0]);
  assign priorExc = ex.fetchError | ex.instReserved | ex.overflow |
                    ex.syscall | ex.brk | ex.eret;
  assign access   = MEM_valid & (isLoad | isStore) & ~misalign & ~priorExc & ~cancel;
  assign stAlign  = storeAlign(sizeCode, addrLo, ex.storeData);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stateQ <= IDLE;
    else         stateQ <= stateD;
  end

  // A cancel that coincides with the ack simply drops the returned data
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE:  if (access) stateD = REQ;
      REQ: begin
        if (dm.dm_ack)   stateD = cancel ? IDLE : DONE;
        else if (cancel) stateD = DRAIN;
      end
      DONE:  if (WB_allow_in || cancel) stateD = IDLE;
      DRAIN: if (dm.dm_ack) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    dmWrD    = dmWrQ;
    dmAddrD  = dmAddrQ;
    dmWstrbD = dmWstrbQ;
    dmWdataD = dmWdataQ;
    rdataD   = rdataQ;
    if (stateQ == IDLE && access) begin
      dmWrD    = isStore;
      dmAddrD  = {ex.exeResult[31:2], 2'b00};
      dmWstrbD = stAlign.wstrb;
      dmWdataD = stAlign.wdata;
    end
    if (stateQ == REQ && dm.dm_ack && !cancel) rdataD = dm.dm_rdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dmWrQ    <= 1'b0;
      dmAddrQ  <= '0;
      dmWstrbQ <= '0;
      dmWdataQ <= '0;
      rdataQ   <= '0;
    end else begin
      dmWrQ    <= dmWrD;
      dmAddrQ  <= dmAddrD;
      dmWstrbQ <= dmWstrbD;
      dmWdataQ <= dmWdataD;
      rdataQ   <= rdataD;
    end
  end

  load_align uLoadAlign (
    .rdata_i (rdataQ),
    .addr_i  (addrLo),
    .size_i  (sizeCode),
    .sign_i  (signExt),
    .data_o  (loadData)
  );

  always_comb begin
    dmReq      = (stateQ == REQ) || (stateQ == DRAIN);
    memOver    = 1'b0;
    useCapture = 1'b0;
    case (stateQ)
      IDLE:    memOver = MEM_valid & ~cancel & ~access;
      DONE: begin
        memOver    = 1'b1;
        useCapture = 1'b1;
      end
      default: memOver = 1'b0;
    endcase
    memOver = memOver & resetn;

    wb              = '0;
    wb.wen          = ex.wen;
    wb.wdest        = ex.wdest;
    wb.memResult    = useCapture ? loadData : ex.exeResult;
    wb.loResult     = ex.loResult;
    wb.hiWrite      = ex.hiWrite;
    wb.loWrite      = ex.loWrite;
    wb.mfhi         = ex.mfhi;
    wb.mflo         = ex.mflo;
    wb.mtc0         = ex.mtc0;
    wb.mfc0         = ex.mfc0;
    wb.cp0rAddr     = ex.cp0rAddr;
    wb.syscall      = ex.syscall;
    wb.eret         = ex.eret;
    wb.brk          = ex.brk;
    wb.fetchError   = ex.fetchError;
    wb.instReserved = ex.instReserved;
    wb.raddrError   = isLoad & misalign;
    wb.waddrError   = isStore & misalign;
    wb.overflow     = ex.overflow;
    wb.dmAddr       = ex.exeResult;
    wb.delaySlot    = ex.delaySlot;
    wb.pc           = ex.pc;
  end

  assign MEM_over    = memOver;
  assign MEM_WB_bus  = wb;
  assign MEM_wdest   = ex.wdest & {5{MEM_valid}};
  assign MEM_pc      = ex.pc;

  assign dm.dm_req   = dmReq;
  assign dm.dm_wr    = dmWrQ;
  assign dm.dm_addr  = dmAddrQ;
  assign dm.dm_wstrb = dmWstrbQ;
  assign dm.dm_wdata = dmWdataQ;

endmodule

// File: doc/mem.md
# mem

Memory-access stage of the five-stage MIPS pipeline, between the EXE stage and the write-back stage. It takes the EXE→MEM bus and issues at most one data-memory access per instruction over a req/ack handshake that tolerates wait states. It aligns store data and strobes, extracts and extends load data, detects misaligned addresses, and produces the 157-bit MEM→WB bus that write-back consumes.

## Interface
- No parameters; widths are fixed by the package.
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- MEM_valid  in  1  MEM stage holds a valid instruction.
- EXE_MEM_bus_r  in  160  fields, MSB first:
  - mem_ctrl[4:0] = {load, store, size[1:0] (00 byte, 01 half, 10 word), sign}
  - store_data[31:0], exe_result[31:0], lo_result[31:0]
  - hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr[7:0]
  - syscall, eret, break, fetch_error, inst_reserved, overflow, delay_slot, wen, wdest[4:0], pc[31:0]
- WB_allow_in  in  1  write-back accepts the MEM result this cycle.
- cancel  in  1  flush from write-back.
- MEM_over  out  1  MEM_WB_bus is complete and valid.
- MEM_WB_bus  out  157  fields, MSB first:
  - wen, wdest, mem_result, lo_result
  - hi_write, lo_write, mfhi, mflo, mtc0, mfc0, cp0r_addr
  - syscall, eret, break, fetch_error, inst_reserved, raddr_error, waddr_error, overflow
  - dm_addr(=exe_result), delay_slot, pc
- MEM_wdest  out  5  wdest & {5{MEM_valid}}.
- MEM_pc  out  32  pc.
- dm_req  out  1  access request; held until dm_ack.
- dm_wr  out  1  1 = store.
- dm_addr  out  32  {exe_result[31:2], 2'b00}.
- dm_wstrb  out  4  byte write enables.
- dm_wdata  out  32  replicated store data.
- dm_rdata  in  32  load data, valid with dm_ack.
- dm_ack  in  1  one-cycle completion pulse; only legal while dm_req=1.

## Operation
- **Classification**
  - misalign: size=word and addr[1:0]≠0, or size=half and addr[0]≠0.
  - raddr_error = load & misalign; waddr_error = store & misalign.
  - prior_exc = fetch_error | inst_reserved | overflow | syscall | break | eret.
  - access = MEM_valid & (load|store) & !misalign & !prior_exc & !cancel.
- **States**
  - IDLE:
    - if access, register the dm_* outputs and go to REQ.
    - otherwise MEM_over = MEM_valid & !cancel, with combinational pass-through (mem_result = exe_result).
  - REQ: dm_req=1 and outputs are held. On dm_ack, capture dm_rdata and go to DONE. On cancel without ack, go to DRAIN.
  - DONE: MEM_over=1 and the captured data drives mem_result. Go to IDLE on WB_allow_in or on cancel.
  - DRAIN: dm_req held until dm_ack; data is discarded; then IDLE. MEM_over=0.
- cancel together with dm_ack in REQ: discard the data and go to IDLE.
- **Store alignment**
  - SB: wstrb = 0001 << addr[1:0], wdata = {4{sd[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{sd[15:0]}}.
  - SW: wstrb = 1111, wdata = sd.
- **Load extraction**
  - byte = rdata[8·addr[1:0] +: 8]; half = rdata[16·addr[1] +: 16].
  - Extend with sign when sign=1, else with zeros; word loads pass unchanged.
- Faulting or prior-exception instructions never issue an access. Their flags pass through, and wen is forwarded unchanged because write-back masks it.

## Timing
- **Reset values:** state=IDLE, dm_req=0, dm_wr=0, dm_addr=0, dm_wstrb=0, dm_wdata=0, capture register=0, MEM_over=0 (gated by resetn).
- Non-memory, misaligned or excepting instruction: MEM_over in the same cycle it arrives (0-cycle latency).
- Memory access:
  - cycle 0 IDLE; dm_req rises in cycle 1.
  - With the ack in cycle N ≥ 1, MEM_over=1 from cycle N+1.
  - Minimum latency is 2 cycles.
- Only one outstanding request at any time; dm_addr, dm_wstrb and dm_wdata are stable while dm_req=1.
- Reset asserted mid-access: dm_req drops immediately. The memory side must drop any pending ack.

## Structure
- **mem_pkg:**
  - state enum (IDLE, REQ, DONE, DRAIN)
  - size codes
  - bus width constants: 160 and 157
  - mem_ctrl field offsets
- **Sub-module load_align:** combinational byte/half select and extension from (rdata, addr[1:0], size, sign).

## Test plan
- LW addr 0x100, ack 3 cycles after dm_req, rdata 0xDEADBEEF -> dm_req high for 3 cycles; MEM_over the next cycle; mem_result 0xDEADBEEF.
- rdata 0x80FF1234:
  - LB @0x103 -> 0xFFFFFF80
  - LBU @0x103 -> 0x00000080
  - LH @0x102 -> 0xFFFF80FF
  - LHU @0x100 -> 0x00001234
- SH @0x202, sd 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD; SB @0x201 sd 0x5A -> wstrb 0010, wdata 0x5A5A5A5A.
- LW @0x101 -> no dm_req, MEM_over in the same cycle, raddr_error=1, bus dm_addr 0x101; SW with overflow=1 -> no dm_req.
- Cancel:
  - store valid with cancel in IDLE -> dm_req stays 0.
  - cancel in REQ, ack 2 cycles later -> DRAIN, dm_req held until the ack, MEM_over stays 0, then IDLE.
- DONE with WB_allow_in=0 for 4 cycles -> MEM_over and bus stable, then IDLE. resetn low during REQ -> dm_req 0 with no clock edge.
